dmem_arbiter: RTL
=================

# dmem_arbiter

Arbiter and access sequencer for the single-port data memory behind the MEM stage. It shares the memory between the pipeline's load/store path (driven from the EX/MEM register outputs) and an external DMA/debug port. It inserts the configured memory wait states and produces the stall that freezes the pipeline registers while a CPU access is pending. Arbitration is CPU-priority with a starvation guard for the DMA port.

## Interface
- WAIT_CYC, 2: memory access length in cycles, legal range 1..15.
- STARVE_MAX, 4: maximum consecutive CPU grants while DMA waits, legal range 1..15.
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  MEM stage holds a load or store.
- cpu_we  in  1  1 = store.
- cpu_addr  in  32  byte address (ALUResultM).
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, valid in the completion cycle.
- cpu_stall  out  1  freeze IF/ID/EX/MEM registers.
- dma_req, dma_we  in  1 each  DMA request and write enable.
- dma_addr, dma_wdata  in  32 each  DMA address and write data.
- dma_gnt  out  1  DMA access in progress.
- dma_done  out  1  DMA completion cycle.
- dma_rdata  out  32  registered DMA read data.
- mem_en, mem_we  out  1 each  memory enable and write strobe.
- mem_addr, mem_wdata  out  32 each  memory address and write data.
- mem_rdata  in  32  memory read data, combinational, valid in the last access cycle.

## Operation
- States: IDLE, CPU_BUSY, DMA_BUSY. A 4-bit wait counter `cnt` counts from 0 to WAIT_CYC-1 in the BUSY states.
- Arbitration occurs only in IDLE. Priority order:
  - DMA wins if dma_req && (!cpu_req || streak == STARVE_MAX).
  - Otherwise CPU wins if cpu_req.
  - Otherwise stay in IDLE.
- The granted state is entered on the next edge with cnt = 0.
- The completion cycle is the BUSY cycle with cnt == WAIT_CYC-1. The next state after completion is always IDLE. Accesses are never preempted.
- streak (4-bit) is updated at each IDLE grant:
  - CPU grant with dma_req high: +1, saturating at STARVE_MAX.
  - DMA grant: cleared to 0.
  - CPU grant with dma_req low: cleared to 0.
- Memory outputs in BUSY states:
  - mem_en = 1.
  - mem_addr and mem_wdata come from the granted source.
  - mem_we = granted we && completion cycle, giving exactly one write commit.
- In IDLE, mem_en, mem_we, mem_addr and mem_wdata are all 0.
- CPU side:
  - cpu_stall = cpu_req && !(CPU_BUSY && completion cycle).
  - cpu_rdata = mem_rdata in a CPU completion cycle, otherwise 0.
- DMA side:
  - dma_gnt = DMA_BUSY.
  - dma_done = DMA_BUSY && completion cycle.
  - dma_rdata is captured from mem_rdata at the edge ending a DMA read completion and held until the next DMA read completion.
- Requester rules:
  - CPU inputs must stay stable while cpu_stall is high.
  - DMA inputs must stay stable from request until dma_done.
  - dma_req must drop on the edge after dma_done unless another access is wanted.

## Timing
- Reset (asynchronous, or RST low at any time, including mid-access):
  - state = IDLE, cnt = 0, streak = 0, dma_rdata = 0.
  - All outputs are 0, cpu_stall included once cpu_req is low.
  - An aborted write never asserts mem_we.
- Uncontended CPU access:
  - The request is seen in IDLE cycle t; cpu_stall is high for cycles t..t+WAIT_CYC-1.
  - BUSY spans t+1..t+WAIT_CYC.
  - cpu_stall is low and data is valid at t+WAIT_CYC, where the MEM/WB register samples it.
- Every access costs 1 + WAIT_CYC cycles of memory occupancy.
- Back-to-back CPU requests each incur the IDLE arbitration cycle.
- Simultaneous requests in IDLE follow the arbitration rule above. Requests arriving mid-access wait for IDLE.
- A cpu_req falling during CPU_BUSY (a flush) does not abort the access. The access completes, its write still commits, and cpu_stall follows cpu_req.

## Test plan
- RST low mid-DMA write (WAIT_CYC=2, cnt=0) -> all outputs 0 immediately, no mem_we pulse, IDLE after release.
- CPU load of 0x100 alone (WAIT_CYC=2), mem_rdata=0xDEADBEEF -> cpu_stall high 2 cycles; mem_en high cycles 2-3; cycle 3 shows cpu_stall=0 and cpu_rdata=0xDEADBEEF.
- CPU store of 0x55AA to 0x200 -> mem_we high only in the second BUSY cycle; mem_addr=0x200 and mem_wdata=0x55AA throughout BUSY.
- DMA read alone of 0x40, mem_rdata=0x12345678 -> dma_gnt 2 cycles, dma_done in the second, dma_rdata=0x12345678 from the next cycle and held.
- STARVE_MAX=2 with cpu_req and dma_req held continuously -> grant order CPU, CPU, DMA, CPU, CPU, DMA.
- cpu_req dropped during CPU_BUSY of a store -> access completes, mem_we pulses once, then IDLE.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundle of every bus signal around the data-memory arbiter. The CPU
// load/store path, the DMA/debug port and the single-port memory all
// connect through it.
//   master : requester/environment side. Drives the CPU and DMA requests and
//            the memory read data. Observes the stall, grants and memory
//            strobes.
//   slave  : arbiter side (dmem_arbiter).
// ----------------------------------------------------------------------------
interface dmem_arbiter_if;
    // CPU (EX/MEM) load/store path
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    // DMA / debug port
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_done;
    logic [31:0] dma_rdata;
    // single-port data memory
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  dma_gnt, dma_done, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output dma_gnt, dma_done, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the MEM-stage load/store path
// and a DMA/debug port. Each access holds the memory for WAIT_CYC cycles
// after a one-cycle IDLE arbitration slot. The CPU has priority. A streak
// counter hands the memory to a waiting DMA after STARVE_MAX consecutive
// contended CPU grants.
// Ports:
//   CLK  : clock
//   RST  : asynchronous, active-low reset
//   bus  : dmem_arbiter_if.slave. CPU request/stall/read data, DMA
//          request/grant/done/read data, and memory strobes/address/data.
// Parameters:
//   WAIT_CYC   : memory access length in cycles (1..15)
//   STARVE_MAX : max consecutive CPU grants while DMA waits (1..15)
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int WAIT_CYC   = 2,
    parameter int STARVE_MAX = 4
) (
    input logic           CLK,
    input logic           RST,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CPU_BUSY, DMA_BUSY} state_t;

    localparam logic [3:0] LAST_CNT  = 4'(WAIT_CYC - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [3:0]  streak, streak_nxt;
    logic [31:0] dma_rdata_q;

    // Access descriptor captured at the grant edge. After a flush (cpu_req
    // dropped mid-access) the pipeline may change its inputs, but the access
    // still completes with the address, data and write enable it was granted
    // with.
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic busy;
    logic last;

    assign busy = (state != IDLE);
    assign last = busy && (cnt == LAST_CNT);

    // ------------------------------------------------------------------
    // Next-state logic: arbitration in IDLE, wait counting in BUSY.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement, so
        // no path leaves it unassigned and no latch is inferred.
        state_nxt  = state;
        cnt_nxt    = cnt;
        streak_nxt = streak;
        case (state)
            IDLE: begin
                cnt_nxt = 4'd0;
                if (bus.dma_req && (!bus.cpu_req || streak == STARVE_LIM)) begin
                    state_nxt  = DMA_BUSY;
                    streak_nxt = 4'd0;
                end else if (bus.cpu_req) begin
                    state_nxt = CPU_BUSY;
                    if (!bus.dma_req)
                        streak_nxt = 4'd0;
                    else if (streak != STARVE_LIM)
                        streak_nxt = streak + 4'd1;
                end
            end
            CPU_BUSY, DMA_BUSY: begin
                // Accesses are never preempted; completion always returns to IDLE.
                if (cnt == LAST_CNT) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            streak <= 4'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            streak <= streak_nxt;
        end
    end

    // Latch the winning source's descriptor when leaving IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_we    <= 1'b0;
            acc_addr  <= 32'd0;
            acc_wdata <= 32'd0;
        end else if (state == IDLE) begin
            if (state_nxt == DMA_BUSY) begin
                acc_we    <= bus.dma_we;
                acc_addr  <= bus.dma_addr;
                acc_wdata <= bus.dma_wdata;
            end else if (state_nxt == CPU_BUSY) begin
                acc_we    <= bus.cpu_we;
                acc_addr  <= bus.cpu_addr;
                acc_wdata <= bus.cpu_wdata;
            end
        end
    end

    // DMA read data is held until the next DMA read completes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            dma_rdata_q <= 32'd0;
        else if (state == DMA_BUSY && last && !acc_we)
            dma_rdata_q <= bus.mem_rdata;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_en    = busy;
    // The write strobe appears only in the completion cycle. An access cut
    // off by reset therefore never commits.
    assign bus.mem_we    = last && acc_we;
    assign bus.mem_addr  = busy ? acc_addr  : 32'd0;
    assign bus.mem_wdata = busy ? acc_wdata : 32'd0;

    assign bus.cpu_stall = bus.cpu_req && !(state == CPU_BUSY && last);
    assign bus.cpu_rdata = (state == CPU_BUSY && last) ? bus.mem_rdata : 32'd0;

    assign bus.dma_gnt   = (state == DMA_BUSY);
    assign bus.dma_done  = (state == DMA_BUSY) && last;
    assign bus.dma_rdata = dma_rdata_q;

endmodule
